// File: rtl/vx_tex_sampler_pkg.sv
// rtl/vx_tex_sampler_pkg.sv - texture sampler format codes, channel offsets and texel type
package vx_tex_sampler_pkg;

    localparam int TEX_FORMAT_BITS = 3;
    localparam int TEX_FILTER_BITS = 2;

    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_R8G8B8A8 = 3'd0;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_R5G6B5   = 3'd1;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_R4G4B4A4 = 3'd2;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_L8       = 3'd3;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_A8       = 3'd4;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FMT_L8A8     = 3'd5;

    localparam int TEX_R_OFF = 0;
    localparam int TEX_G_OFF = 8;
    localparam int TEX_B_OFF = 16;
    localparam int TEX_A_OFF = 24;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgba8_t;

endpackage

// File: rtl/vx_tex_sampler_format.sv
// rtl/vx_tex_sampler_format.sv - combinational unpack of one fetched texel to RGBA8
module vx_tex_sampler_format
    import vx_tex_sampler_pkg::*;
(
    input  logic [TEX_FORMAT_BITS-1:0] format_i,
    input  logic [31:0]                texel_i,
    output logic [31:0]                color_o
);

    rgba8_t c;

    // Narrow channels are widened by replicating their MSBs into the low bits.
    always_comb begin
        c.r = texel_i[TEX_R_OFF +: 8];
        c.g = texel_i[TEX_G_OFF +: 8];
        c.b = texel_i[TEX_B_OFF +: 8];
        c.a = texel_i[TEX_A_OFF +: 8];
        case (format_i)
            TEX_FMT_R5G6B5: begin
                c.r = {texel_i[15:11], texel_i[15:13]};
                c.g = {texel_i[10:5],  texel_i[10:9]};
                c.b = {texel_i[4:0],   texel_i[4:2]};
                c.a = 8'hFF;
            end
            TEX_FMT_R4G4B4A4: begin
                c.r = {texel_i[15:12], texel_i[15:12]};
                c.g = {texel_i[11:8],  texel_i[11:8]};
                c.b = {texel_i[7:4],   texel_i[7:4]};
                c.a = {texel_i[3:0],   texel_i[3:0]};
            end
            TEX_FMT_L8: begin
                c.r = texel_i[7:0];
                c.g = texel_i[7:0];
                c.b = texel_i[7:0];
                c.a = 8'hFF;
            end
            TEX_FMT_A8: begin
                c.r = 8'h00;
                c.g = 8'h00;
                c.b = 8'h00;
                c.a = texel_i[7:0];
            end
            TEX_FMT_L8A8: begin
                c.r = texel_i[7:0];
                c.g = texel_i[7:0];
                c.b = texel_i[7:0];
                c.a = texel_i[15:8];
            end
            default: ;
        endcase
    end

    assign color_o = c;

endmodule

// File: rtl/vx_tex_sampler.sv
// rtl/vx_tex_sampler.sv - pipelined point/bilinear texel sampler (unpack, h-lerp, v-lerp, output)
module vx_tex_sampler
    import vx_tex_sampler_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_REQS  = 1,
    parameter int REQ_INFOW = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [NUM_REQS-1:0]        req_tmask,
    input  logic [TEX_FORMAT_BITS-1:0] req_format,
    input  logic [TEX_FILTER_BITS-1:0] req_filter,
    input  logic [NUM_REQS*16-1:0]     req_blends,
    input  logic [NUM_REQS*128-1:0]    req_data,
    input  logic [REQ_INFOW-1:0]       req_info,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [NUM_REQS-1:0]        rsp_tmask,
    output logic [NUM_REQS*32-1:0]     rsp_data,
    output logic [REQ_INFOW-1:0]       rsp_info,
    input  logic                       rsp_ready
);

    function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [16:0] sum;
        sum = {9'd0, a} * (17'd256 - {9'd0, f}) + {9'd0, b} * {9'd0, f} + 17'd128;
        return sum[15:8];
    endfunction

    function automatic logic [31:0] lerp_rgba(input logic [31:0] a, input logic [31:0] b, input logic [7:0] f);
        logic [31:0] res;
        for (int c = 0; c < 4; c++) begin
            res[c*8 +: 8] = lerp8(a[c*8 +: 8], b[c*8 +: 8], f);
        end
        return res;
    endfunction

    logic s0_valid_q, s1_valid_q, s2_valid_q, rsp_valid_q;
    logic out_en, s2_en, s1_en, s0_en;

    // A stage may load when empty or when everything downstream of it is moving.
    assign out_en    = ~rsp_valid_q | rsp_ready;
    assign s2_en     = ~s2_valid_q | out_en;
    assign s1_en     = ~s1_valid_q | s2_en;
    assign s0_en     = ~s0_valid_q | s1_en;
    assign req_ready = s0_en;

    logic [NUM_REQS-1:0][3:0][31:0] unpacked;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
        for (genvar j = 0; j < 4; j++) begin : g_texel
            vx_tex_sampler_format u_format (
                .format_i (req_format),
                .texel_i  (req_data[(i*4+j)*32 +: 32]),
                .color_o  (unpacked[i][j])
            );
        end
    end

    logic [NUM_REQS-1:0][3:0][31:0] s0_texel_q;
    logic [NUM_REQS-1:0][7:0]       fu_d, fv_d, s0_fu_q, s0_fv_q, s1_fv_q;
    logic [NUM_REQS-1:0][31:0]      row0_d, row1_d, color_d;
    logic [NUM_REQS-1:0][31:0]      s1_row0_q, s1_row1_q, s2_color_q, rsp_data_q;
    logic [NUM_REQS-1:0]            s0_tmask_q, s1_tmask_q, s2_tmask_q, rsp_tmask_q;
    logic [REQ_INFOW-1:0]           s0_info_q, s1_info_q, s2_info_q, rsp_info_q;

    // Point sampling zeroes both weights so the lerps pass t0 through unchanged.
    always_comb begin
        fu_d = '0;
        fv_d = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_filter != '0) begin
                fu_d[i] = req_blends[i*16 +: 8];
                fv_d[i] = req_blends[i*16+8 +: 8];
            end
        end
    end

    always_comb begin
        row0_d  = '0;
        row1_d  = '0;
        color_d = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            row0_d[i] = lerp_rgba(s0_texel_q[i][0], s0_texel_q[i][1], s0_fu_q[i]);
            row1_d[i] = lerp_rgba(s0_texel_q[i][2], s0_texel_q[i][3], s0_fu_q[i]);
            if (s1_tmask_q[i]) begin
                color_d[i] = lerp_rgba(s1_row0_q[i], s1_row1_q[i], s1_fv_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (s0_en)  s0_valid_q  <= req_valid;
            if (s1_en)  s1_valid_q  <= s0_valid_q;
            if (s2_en)  s2_valid_q  <= s1_valid_q;
            if (out_en) rsp_valid_q <= s2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (s0_en) begin
            s0_texel_q <= unpacked;
            s0_fu_q    <= fu_d;
            s0_fv_q    <= fv_d;
            s0_tmask_q <= req_tmask;
            s0_info_q  <= req_info;
        end
        if (s1_en) begin
            s1_row0_q  <= row0_d;
            s1_row1_q  <= row1_d;
            s1_fv_q    <= s0_fv_q;
            s1_tmask_q <= s0_tmask_q;
            s1_info_q  <= s0_info_q;
        end
        if (s2_en) begin
            s2_color_q <= color_d;
            s2_tmask_q <= s1_tmask_q;
            s2_info_q  <= s1_info_q;
        end
        if (out_en) begin
            rsp_data_q  <= s2_color_q;
            rsp_tmask_q <= s2_tmask_q;
            rsp_info_q  <= s2_info_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tmask = rsp_tmask_q;
    assign rsp_info  = rsp_info_q;

endmodule

// File: tb/tb_vx_tex_sampler.sv
// tb/tb_vx_tex_sampler.sv - randomized scoreboard bench for vx_tex_sampler
module tb_vx_tex_sampler;
    import vx_tex_sampler_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       req_valid;
    logic [3:0]                 req_tmask;
    logic [TEX_FORMAT_BITS-1:0] req_format;
    logic [TEX_FILTER_BITS-1:0] req_filter;
    logic [63:0]                req_blends;
    logic [511:0]               req_data;
    logic [7:0]                 req_info;
    logic                       req_ready;
    logic                       rsp_valid;
    logic [3:0]                 rsp_tmask;
    logic [127:0]               rsp_data;
    logic [7:0]                 rsp_info;
    logic                       rsp_ready;

    vx_tex_sampler #(.CORE_ID(0), .NUM_REQS(4), .REQ_INFOW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_tmask  (req_tmask),
        .req_format (req_format),
        .req_filter (req_filter),
        .req_blends (req_blends),
        .req_data   (req_data),
        .req_info   (req_info),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_tmask  (rsp_tmask),
        .rsp_data   (rsp_data),
        .rsp_info   (rsp_info),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tmask;
        logic [7:0]   info;
        int           edge_no;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           fire_edge = 0;
    bit           fire_seen = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_data;
    logic [12:0]  prev_meta;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic int rep(input int x, input int n);
        return ((x << (8 - n)) | (x >> (2 * n - 8))) & 255;
    endfunction

    function automatic int unpack_model(input int fmt, input logic [31:0] t);
        int unsigned tu;
        int r, g, b, a;
        tu = t;
        r = tu & 255; g = (tu >> 8) & 255; b = (tu >> 16) & 255; a = (tu >> 24) & 255;
        case (fmt)
            1: begin r = rep((tu >> 11) & 31, 5); g = rep((tu >> 5) & 63, 6); b = rep(tu & 31, 5); a = 255; end
            2: begin r = rep((tu >> 12) & 15, 4); g = rep((tu >> 8) & 15, 4); b = rep((tu >> 4) & 15, 4); a = rep(tu & 15, 4); end
            3: begin r = tu & 255; g = r; b = r; a = 255; end
            4: begin r = 0; g = 0; b = 0; a = tu & 255; end
            5: begin r = tu & 255; g = r; b = r; a = (tu >> 8) & 255; end
            default: ;
        endcase
        return r | (g << 8) | (b << 16) | (a << 24);
    endfunction

    function automatic int lerp_m(input int a, input int b, input int f);
        return (a * (256 - f) + b * f + 128) / 256;
    endfunction

    function automatic logic [127:0] model(input int fmt, input bit bilinear, input logic [3:0] tmask,
                                           input logic [511:0] data, input logic [63:0] blends);
        logic [127:0] res;
        int t[4];
        int fu, fv, top, bot, ch, out;
        res = '0;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 4; j++) t[j] = unpack_model(fmt, data[(l*4+j)*32 +: 32]);
            fu = int'(blends[l*16 +: 8]);
            fv = int'(blends[l*16+8 +: 8]);
            out = 0;
            if (!bilinear) out = t[0];
            else begin
                for (int k = 0; k < 4; k++) begin
                    top = lerp_m((t[0] >> (8*k)) & 255, (t[1] >> (8*k)) & 255, fu);
                    bot = lerp_m((t[2] >> (8*k)) & 255, (t[3] >> (8*k)) & 255, fu);
                    ch  = lerp_m(top, bot, fv);
                    out = out | (ch << (8*k));
                end
            end
            if (tmask[l]) res[l*32 +: 32] = 32'(out);
        end
        return res;
    endfunction

    // Scoreboard, hold-while-stalled and reset-flush checks, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
            exp_q.delete();
            prev_stall = 0;
            fire_seen  = 0;
        end else begin
            fire_seen = req_valid && req_ready;
            if (fire_seen) begin
                e.data    = model(int'(req_format), req_filter != '0, req_tmask, req_data, req_blends);
                e.tmask   = req_tmask;
                e.info    = req_info;
                e.edge_no = cyc + 1;
                exp_q.push_back(e);
            end
            if (prev_stall) begin
                chk("hold_data", rsp_data, prev_data);
                chk("hold_meta", 128'({rsp_valid, rsp_tmask, rsp_info}), 128'(prev_meta));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 128'(rsp_info), 128'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_meta", 128'({rsp_tmask, rsp_info}), 128'({e.tmask, e.info}));
                    chk("latency_min", 128'(cyc - e.edge_no >= 3), 128'd1);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_meta  = {rsp_valid, rsp_tmask, rsp_info};
        end
    end

    task automatic send();
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 128'd0, 128'd1);
        else fire_edge = cyc + 1;
        @(posedge clk); #1;
    endtask

    task automatic rand_req(input int info);
        req_format = 3'($urandom_range(0, 7));
        req_filter = 2'($urandom_range(0, 3));
        req_tmask  = 4'($urandom);
        for (int w = 0; w < 16; w++) req_data[w*32 +: 32] = $urandom;
        for (int w = 0; w < 2; w++) req_blends[w*32 +: 32] = $urandom;
        for (int l = 0; l < 4; l++) if ($urandom_range(0, 3) == 0) req_blends[l*16 +: 8] = 8'hFF;
        req_info = 8'(info);
    endtask

    task automatic set_req(input int fmt, input int filt, input logic [3:0] tmask,
                           input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                           input logic [31:0] t3, input logic [7:0] fu, input logic [7:0] fv);
        req_format = 3'(fmt);
        req_filter = 2'(filt);
        req_tmask  = tmask;
        req_info   = 8'($urandom);
        for (int l = 0; l < 4; l++) begin
            req_data[l*128 +: 128] = {t3, t2, t1, t0};
            req_blends[l*16 +: 16] = {fv, fu};
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic directed(input string name, input int fmt, input int filt, input logic [3:0] tmask,
                            input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                            input logic [31:0] t3, input logic [7:0] fu, input logic [7:0] fv,
                            input logic [127:0] want);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        rsp_ready = 1'b1;
        set_req(fmt, filt, tmask, t0, t1, t2, t3, fu, fv);
        send();
        req_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; lat = cyc - fire_edge; break; end
        end
        if (!got) chk({name, "_timeout"}, 128'd0, 128'd1);
        else begin
            chk(name, rsp_data, want);
            chk({name, "_lat"}, 128'(lat), 128'd3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int  idx;
        bit  rr;
        int  seen;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_tmask = '0; req_format = '0; req_filter = '0;
        req_blends = '0; req_data = '0; req_info = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("post_reset_req_ready", 128'(req_ready), 128'd1);
        @(posedge clk); #1;

        directed("fmt0_point", 0, 0, 4'b0001, 32'h11223344, 32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5, 8'd77, 8'd200, {96'h0, 32'h11223344});
        directed("fmt0_bilin_fu128", 0, 1, 4'b0001, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 8'd128, 8'd0, {96'h0, 32'h80808080});
        directed("fmt1_point", 1, 0, 4'b0001, 32'h0000F800, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'hFF0000FF});
        directed("fmt3_point", 3, 0, 4'b0001, 32'h0000005A, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'hFF5A5A5A});
        directed("fmt4_point", 4, 0, 4'b0001, 32'h0000005A, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'h5A000000});
        directed("tmask_0101", 0, 0, 4'b0101, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF});
        directed("fmt2_point", 2, 0, 4'b0001, 32'h00001234, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'h44332211});
        directed("fmt5_point", 5, 0, 4'b0001, 32'h0000C35A, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'hC35A5A5A});
        directed("fmt7_as_fmt0", 7, 0, 4'b0001, 32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, {96'h0, 32'hA1B2C3D4});
        directed("bilin_fv255", 0, 2, 4'b0001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0, 8'd255, {96'h0, 32'hFEFEFEFE});
        directed("tmask_zero", 0, 0, 4'b0000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 128'h0);

        // Back-to-back with the consumer stalled: four fill the pipe, the fifth waits.
        idx = 0;
        rr  = 0;
        rsp_ready = 1'b0;
        rand_req(idx);
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rr = req_ready;
            if (rr) idx++;
            @(posedge clk); #1;
            if (rr) rand_req(idx);
        end
        chk("stall_accepted", 128'(idx), 128'd4);
        chk("stall_req_ready", 128'(rr), 128'd0);
        rsp_ready = 1'b1;
        send();
        rand_req(5);
        send();
        drain();

        // Reset with three requests in flight: none of them may come out.
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_req(100 + k);
            send();
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_rsp_valid", 128'(rsp_valid), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_req_ready", 128'(req_ready), 128'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midreset_no_rsp", 128'(seen), 128'd0);
        @(posedge clk); #1;

        // Random traffic with random backpressure.
        idx = 200;
        for (int k = 0; k < 400; k++) begin
            if (!req_valid || fire_seen) begin
                if ($urandom_range(0, 9) < 7) begin
                    rand_req(idx);
                    idx++;
                    req_valid = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_tex_sampler.md
VX_TEX_SAMPLER -- requirements
Module: VX_tex_sampler

Interface
REQ-001 SHALL have parameter CORE_ID, default 0: core index, used for debug trace only.
REQ-002 SHALL have parameter NUM_REQS, default 1: number of lanes.
REQ-003 SHALL have parameter REQ_INFOW, default 1: width of the opaque sideband carried with each request.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1: request valid.
REQ-007 SHALL have port req_tmask, input, NUM_REQS: active lanes.
REQ-008 SHALL have port req_format, input, `TEX_FORMAT_BITS: texel format code.
REQ-009 SHALL have port req_filter, input, `TEX_FILTER_BITS: 0 = point, nonzero = bilinear.
REQ-010 SHALL have port req_blends, input, NUM_REQS x 2 x 8: per lane fu at index 0 and fv at index 1, range 0..255.
REQ-011 SHALL have port req_data, input, NUM_REQS x 4 x 32: texels t0(u0,v0), t1(u1,v0), t2(u0,v1), t3(u1,v1), LSB-aligned as fetched.
REQ-012 SHALL have port req_info, input, REQ_INFOW: sideband.
REQ-013 SHALL have port req_ready, output, 1: request accepted when high together with req_valid.
REQ-014 SHALL have port rsp_valid, output, 1: response valid.
REQ-015 SHALL have port rsp_tmask, output, NUM_REQS: copy of req_tmask.
REQ-016 SHALL have port rsp_data, output, NUM_REQS x 32: RGBA8 per lane, R[7:0], G[15:8], B[23:16], A[31:24].
REQ-017 SHALL have port rsp_info, output, REQ_INFOW: copy of req_info.
REQ-018 SHALL have port rsp_ready, input, 1: consumer ready.

Function
REQ-019 SHALL be a 3-stage pipeline: S0 format unpack, S1 horizontal lerp, S2 vertical lerp, with a registered output.
REQ-020 SHALL give a latency of exactly 3 cycles from a req fire to rsp_valid when there is no backpressure, with throughput 1 per cycle.
REQ-021 SHALL keep a valid bit per stage, and each stage SHALL load when it is empty or its contents advance in the same cycle (bubble collapsing).
REQ-022 SHALL drive req_ready = ~S0.valid | S0 advancing, combinationally.
REQ-023 SHALL hold rsp_valid and all rsp fields stable while rsp_valid && ~rsp_ready, and SHALL lose or reorder no request.
REQ-024 SHALL unpack format 0 (R8G8B8A8) as [7:0]R [15:8]G [23:16]B [31:24]A.
REQ-025 SHALL unpack format 1 (R5G6B5) as R[15:11] G[10:5] B[4:0], with A = 0xFF.
REQ-026 SHALL unpack format 2 (R4G4B4A4) as R[15:12] G[11:8] B[7:4] A[3:0].
REQ-027 SHALL unpack format 3 (L8) as R=G=B=[7:0] with A = 0xFF.
REQ-028 SHALL unpack format 4 (A8) as R=G=B=0 with A=[7:0].
REQ-029 SHALL unpack format 5 (L8A8) as R=G=B=[7:0] with A=[15:8].
REQ-030 SHALL treat any other format code as format 0.
REQ-031 SHALL expand n-bit channels to 8 bits by MSB replication: 5-bit x gives {x, x[4:2]}, 6-bit gives {x, x[5:4]}, 4-bit gives {x, x}.
REQ-032 SHALL compute lerp(a,b,f) = (a*(256-f) + b*f + 128) >> 8 using 17-bit intermediates, giving an 8-bit result with no overflow.
REQ-033 SHALL, for bilinear, produce per channel lerp(lerp(t0,t1,fu), lerp(t2,t3,fu), fv).
REQ-034 SHALL, for point, output unpacked t0 and ignore t1..t3 and the blends.
REQ-035 SHALL drive rsp_data to 0 for lanes whose tmask bit is 0.
REQ-036 SHALL pass an all-zero tmask request through as a normal transaction.

Reset
REQ-037 SHALL, on asynchronous reset, clear all stage valid bits and rsp_valid, with req_ready high from the first clock after reset release.
REQ-038 SHALL NOT reset datapath registers, and rsp_data, rsp_tmask and rsp_info SHALL be don't-care while rsp_valid = 0.
REQ-039 SHALL, on reset asserted mid-stream, discard all in-flight requests, and no response SHALL appear afterwards for them.

Structure
REQ-040 SHALL place `TEX_FORMAT_BITS, the format code constants and the RGBA8 channel offsets in VX_tex_define.vh.
REQ-041 SHALL implement unpacking in one sub-module, VX_tex_format (combinational, one texel in, 4x8-bit out), instanced NUM_REQS x 4 times.
REQ-042 SHALL implement lerp inline in the top module.

Verification
REQ-043 SHALL cover: format 0, point, t0=0x11223344, tmask=1 -> rsp_data 0x11223344 exactly 3 cycles after fire.
REQ-044 SHALL cover: format 0, bilinear, t0=0x00000000, t1=0xFFFFFFFF, fu=128, fv=0 -> 0x80808080.
REQ-045 SHALL cover: format 1, point, t0=0xF800 -> 0xFF0000FF; format 3, t0=0x5A -> 0xFF5A5A5A; format 4, t0=0x5A -> 0x5A000000.
REQ-046 SHALL cover: NUM_REQS=4, tmask=0b0101, all lanes t0=0xFFFFFFFF, point -> lanes 1 and 3 read 0, lanes 0 and 2 read 0xFFFFFFFF.
REQ-047 SHALL cover: 6 back-to-back requests with rsp_ready low for 5 cycles -> req_ready drops after 4 are held (3 stages plus output), then all 6 responses arrive in order with fields unchanged while stalled.
REQ-048 SHALL cover: reset pulsed with 3 requests in flight -> rsp_valid = 0 within the reset cycle, and none of the 3 responses ever appears.
